rv_fetch_unit: RTL and testbench



---
 rtl/rv_fetch_pkg.sv | 16 +
 rtl/rv_fetch_fifo.sv | 55 +++++
 rtl/rv_fetch_unit.sv | 125 ++++++++++++
 tb/tb_rv_fetch_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch unit.
// RV_FETCH_MISALIGN_CHECK_EN adds a misaligned flag to each fetch entry.
package rv_fetch_pkg;

    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] RV_NOP      = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
`ifdef RV_FETCH_MISALIGN_CHECK_EN
        logic        misaligned;
`endif
    } fetch_entry_t;

endpackage

// File: rtl/rv_fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} entries for decode.
// A flush empties the FIFO; a push in the same cycle becomes the sole entry.
// RV_FETCH_MISALIGN_CHECK_EN only changes the stored entry width.
module rv_fetch_fifo
    import rv_fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    localparam int PW = $clog2(FIFO_DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    fetch_entry_t  mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pop_ok;

    assign empty  = (count == '0);
    assign full   = (count == CW'(FIFO_DEPTH));
    assign pop_ok = pop && !empty;
    assign head   = mem[rd_ptr];

    // Pointer/count update with flush taking priority over normal traffic
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= PW'(push);
            count  <= CW'(push);
            if (push) mem[0] <= push_data;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/rv_fetch_unit.sv
// RV32I instruction fetch: sequential PC generation, in-order response
// capture into a prefetch FIFO, single-cycle redirect with response drop.
// RV_FETCH_MISALIGN_CHECK_EN: misaligned redirect targets produce a NOP
// entry flagged on if_misaligned and halt fetch until the next redirect.
module rv_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
`ifdef RV_FETCH_MISALIGN_CHECK_EN
    output logic        if_misaligned,
`endif
    output logic [31:0] if_instr
);

    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_LIM = (CW+1)'(FIFO_DEPTH);

    logic [31:0]   fetch_pc, rsp_pc, redir_tgt;
    logic [CW-1:0] outstanding, drop_cnt, count;
    logic [CW:0]   inflight;
    logic          fifo_full, fifo_empty;
    logic          push, pop, req_fire, rsp_keep, redir_mis, halted;
    fetch_entry_t  push_entry, head;

`ifdef RV_FETCH_MISALIGN_CHECK_EN
    assign redir_tgt = redirect_pc;
    assign redir_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    assign redir_tgt = redirect_pc & 32'hFFFF_FFFC;
    assign redir_mis = 1'b0;
`endif

    // Issue bound: every accepted request must have a FIFO slot waiting
    assign inflight       = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = !rst && !redirect_valid && !halted && (inflight < DEPTH_LIM);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_keep = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
    assign push     = redir_mis || (rsp_keep && (!fifo_full || pop));
    assign if_valid = !fifo_empty && !redirect_valid;
    assign pop      = if_valid && if_ready;
    assign if_pc    = head.pc;
    assign if_instr = head.instr;
`ifdef RV_FETCH_MISALIGN_CHECK_EN
    assign if_misaligned = head.misaligned;
`endif

    // Push payload: memory response normally, synthetic NOP on a bad target
    always_comb begin
        push_entry = '0;
        if (redir_mis) begin
            push_entry.pc    = redir_tgt;
            push_entry.instr = RV_NOP;
`ifdef RV_FETCH_MISALIGN_CHECK_EN
            push_entry.misaligned = 1'b1;
`endif
        end else begin
            push_entry.pc    = rsp_pc;
            push_entry.instr = imem_rsp_data;
        end
    end

    // PC tracking plus outstanding/drop accounting.
    // outstanding already includes responses queued for dropping, so after a
    // redirect everything still in flight is stale: drop_cnt becomes the
    // remaining outstanding count, which also covers back-to-back redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                fetch_pc <= redir_tgt;
                rsp_pc   <= redir_tgt;
                drop_cnt <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + 32'(INSTR_BYTES);
                if (rsp_keep) rsp_pc <= rsp_pc + 32'(INSTR_BYTES);
                else if (imem_rsp_valid) drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

`ifdef RV_FETCH_MISALIGN_CHECK_EN
    // A misaligned target parks fetch until the next aligned redirect
    always_ff @(posedge clk) begin
        if (rst) halted <= 1'b0;
        else if (redirect_valid) halted <= redir_mis;
    end
`else
    assign halted = 1'b0;
`endif

    rv_fetch_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Directed bench for rv_fetch_unit with a latency-programmable memory model.
// Also builds with RV_FETCH_MISALIGN_CHECK_EN defined.
module tb_rv_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid, imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid, if_ready = 1'b1;
    logic [31:0] if_pc, if_instr;
`ifdef RV_FETCH_MISALIGN_CHECK_EN
    logic        if_misaligned;
`endif

    int checks = 0;
    int errors = 0;
    int lat = 1;
    int acc_cnt = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t q[$];

    rv_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
`ifdef RV_FETCH_MISALIGN_CHECK_EN
        .if_misaligned  (if_misaligned),
`endif
        .if_instr       (if_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    // Memory model: responses change on negedge, requests sampled at negedge+3
    initial begin
        int n;
        mreq_t r;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            imem_rsp_valid = 1'b0;
            if (q.size() > 0 && q[0].due <= n) begin
                r = q.pop_front();
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(r.addr);
            end
            #3;
            if (rst) begin
                q.delete();
                acc_cnt = 0;
            end else if (imem_req_valid && imem_req_ready) begin
                q.push_back('{addr: imem_req_addr, due: n + lat});
                acc_cnt++;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        redirect_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        lat = 1; imem_req_ready = 1'b1; if_ready = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b exp 0", imem_req_valid); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_if_valid got %b exp 0", if_valid); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL rst_if_pc got %h exp 0", if_pc); end
        checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL rst_if_instr got %h exp 0", if_instr); end
        rst = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL rst_first_req got %b/%h exp 1/00000000", imem_req_valid, imem_req_addr); end
    endtask

    // Continues straight from test_reset: cycle 0 already observed
    task automatic test_stream();
        for (int k = 1; k < 10; k++) begin
            tick();
            checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4*k)) begin errors++; $display("FAIL stream_req c%0d got %b/%h exp 1/%h", k, imem_req_valid, imem_req_addr, 32'(4*k)); end
            if (k >= 2) begin
                checks++; if (if_valid !== 1'b1 || if_pc !== 32'(4*(k-2)) || if_instr !== mem_word(32'(4*(k-2)))) begin errors++; $display("FAIL stream_if c%0d got %b/%h/%h exp 1/%h", k, if_valid, if_pc, if_instr, 32'(4*(k-2))); end
            end else begin
                checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL stream_if_early c%0d got %b exp 0", k, if_valid); end
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        lat = 1; imem_req_ready = 1'b1; if_ready = 1'b0;
        reset_dut();
        for (int k = 0; k < 10; k++) begin
            if (if_valid && if_pc !== 32'h0) begin checks++; errors++; $display("FAIL bp_hold c%0d got %h exp 00000000", k, if_pc); end
            tick();
        end
        checks++; if (acc_cnt !== 4) begin errors++; $display("FAIL bp_req_count got %0d exp 4", acc_cnt); end
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin errors++; $display("FAIL bp_head got %b/%h exp 1/00000000", if_valid, if_pc); end
        if_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            if (if_valid) begin
                checks++; if (if_pc !== 32'(4*n) || if_instr !== mem_word(32'(4*n))) begin errors++; $display("FAIL bp_order #%0d got %h/%h exp %h", n, if_pc, if_instr, 32'(4*n)); end
                n++;
            end
            tick();
        end
        checks++; if (n !== 6) begin errors++; $display("FAIL bp_timeout got %0d deliveries exp 6", n); end
    endtask

    task automatic test_req_stall();
        lat = 1; imem_req_ready = 1'b1; if_ready = 1'b1;
        reset_dut();
        repeat (4) tick();
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin errors++; $display("FAIL stall_pre got %b/%h exp 1/00000010", imem_req_valid, imem_req_addr); end
        imem_req_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin errors++; $display("FAIL stall_hold %0d got %b/%h exp 1/00000010", j, imem_req_valid, imem_req_addr); end
        end
        imem_req_ready = 1'b1;
        tick();
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h14) begin errors++; $display("FAIL stall_release got %b/%h exp 1/00000014", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_redirect_latency();
        int c;
        lat = 3; imem_req_ready = 1'b0; if_ready = 1'b1;
        reset_dut();
        imem_req_ready = 1'b1;
        tick();
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        #1;
        checks++; if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL redir_cycle got %b/%b exp 0/0", imem_req_valid, if_valid); end
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin errors++; $display("FAIL redir_req got %b/%h exp 1/00000100", imem_req_valid, imem_req_addr); end
        checks++; if (dut.drop_cnt !== 3'd2) begin errors++; $display("FAIL redir_drop got %0d exp 2", dut.drop_cnt); end
        c = 0;
        while (!if_valid && c < 20) begin tick(); c++; end
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== mem_word(32'h100)) begin errors++; $display("FAIL redir_first got %b/%h/%h exp 1/00000100", if_valid, if_pc, if_instr); end
        tick();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h104) begin errors++; $display("FAIL redir_second got %b/%h exp 1/00000104", if_valid, if_pc); end
    endtask

    task automatic test_redirect_with_rsp();
        int c;
        lat = 2; imem_req_ready = 1'b1; if_ready = 1'b0;
        reset_dut();
        repeat (4) tick();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL rr_pre got %b/%h/%b exp 1/00000000/0", if_valid, if_pc, imem_req_valid); end
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rr_mask got %b exp 0", if_valid); end
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0 || dut.drop_cnt !== 3'd1) begin errors++; $display("FAIL rr_flush got %b/%0d exp 0/1", if_valid, dut.drop_cnt); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin errors++; $display("FAIL rr_req got %b/%h exp 1/00000200", imem_req_valid, imem_req_addr); end
        tick();
        checks++; if (if_valid !== 1'b0 || dut.drop_cnt !== 3'd0) begin errors++; $display("FAIL rr_drained got %b/%0d exp 0/0", if_valid, dut.drop_cnt); end
        if_ready = 1'b1;
        c = 0;
        while (!if_valid && c < 20) begin tick(); c++; end
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_instr !== mem_word(32'h200)) begin errors++; $display("FAIL rr_first got %b/%h/%h exp 1/00000200", if_valid, if_pc, if_instr); end
        tick();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h204) begin errors++; $display("FAIL rr_second got %b/%h exp 1/00000204", if_valid, if_pc); end
    endtask

`ifdef RV_FETCH_MISALIGN_CHECK_EN
    task automatic test_misaligned();
        int a;
        lat = 1; imem_req_ready = 1'b1; if_ready = 1'b0;
        reset_dut();
        repeat (2) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h102 || if_instr !== 32'h13 || if_misaligned !== 1'b1) begin errors++; $display("FAIL mis_entry got %b/%h/%h/%b exp 1/00000102/00000013/1", if_valid, if_pc, if_instr, if_misaligned); end
        a = acc_cnt;
        for (int j = 0; j < 5; j++) begin
            checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL mis_halt c%0d got %b exp 0", j, imem_req_valid); end
            tick();
        end
        checks++; if (acc_cnt !== a) begin errors++; $display("FAIL mis_no_req got %0d exp %0d", acc_cnt, a); end
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300 || if_valid !== 1'b0) begin errors++; $display("FAIL mis_resume got %b/%h/%b exp 1/00000300/0", imem_req_valid, imem_req_addr, if_valid); end
    endtask
`else
    task automatic test_misaligned();
        int c;
        lat = 1; imem_req_ready = 1'b1; if_ready = 1'b1;
        reset_dut();
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h206;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h204) begin errors++; $display("FAIL align_req got %b/%h exp 1/00000204", imem_req_valid, imem_req_addr); end
        c = 0;
        while (!if_valid && c < 20) begin tick(); c++; end
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h204) begin errors++; $display("FAIL align_first got %b/%h exp 1/00000204", if_valid, if_pc); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_req_stall();
        test_redirect_latency();
        test_redirect_with_rsp();
        test_misaligned();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
